// File: rtl/scoreboard_lsu_dat_pipe.sv
// -----------------------------------------------------------------------------
// scoreboard_lsu_dat_pipe
//
// Purpose:
//   Checks the load/store data path of an LSU. Each driver transaction is turned
//   into an expected byte strobe, aligned store data and extended load data,
//   then queued. Each DUT result pops the oldest expectation and is compared
//   against it. The comparison result is registered into check/error counters,
//   a one-cycle mismatch pulse and sticky error flags.
//
// Parameters:
//   DATA_W - load/store data width in bits (32 or 64)
//   DEPTH  - expected-transaction queue depth (power of two, 2..16)
//   CNT_W  - width of the check and error counters (saturating)
//
// Ports:
//   i_clk, i_rst_n   - clock (rising edge), asynchronous active-low reset
//   drv_valid        - driver transaction issued this cycle
//   drv_funct3       - [1:0] size (B/H/W/D), [2] unsigned load
//   drv_lsb_addr     - byte offset within the data word
//   drv_ld_data      - raw memory read data
//   drv_st_data      - register store data
//   act_valid        - DUT result present this cycle
//   act_st_data      - DUT-aligned store data (checked on enabled lanes only)
//   act_st_strb      - DUT byte strobe
//   act_ld_data      - DUT-extended load data
//   o_pending        - queue occupancy (reaches DEPTH when full)
//   o_chk_cnt        - completed comparisons
//   o_err_cnt        - failed comparisons
//   o_mismatch       - one-cycle pulse on a failed comparison
//   o_err_flags      - sticky: [0] overflow, [1] underflow, [2] illegal size,
//                      [3] any mismatch
//
// Build option:
//   SB_LSU_DAT_ERR_MSG_EN - when defined, every mismatch, overflow, underflow
//   and illegal size is reported with $error. Counters and flags are the same
//   either way.
// -----------------------------------------------------------------------------
module scoreboard_lsu_dat_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          drv_valid,
  input  logic [2:0]                    drv_funct3,
  input  logic [$clog2(DATA_W/8)-1:0]   drv_lsb_addr,
  input  logic [DATA_W-1:0]             drv_ld_data,
  input  logic [DATA_W-1:0]             drv_st_data,
  input  logic                          act_valid,
  input  logic [DATA_W-1:0]             act_st_data,
  input  logic [DATA_W/8-1:0]           act_st_strb,
  input  logic [DATA_W-1:0]             act_ld_data,
  output logic [$clog2(DEPTH):0]        o_pending,
  output logic [CNT_W-1:0]              o_chk_cnt,
  output logic [CNT_W-1:0]              o_err_cnt,
  output logic                          o_mismatch,
  output logic [3:0]                    o_err_flags
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SH_W  = OFF_W + 3;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------
  function automatic logic [OFF_W-1:0] align_off(input logic [1:0] size,
                                                 input logic [OFF_W-1:0] off);
    logic [OFF_W-1:0] r;
    r = off;
    case (size)
      2'd0:    r = off;
      2'd1:    r[0] = 1'b0;
      2'd2:    r[1:0] = 2'b00;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [NB-1:0] size_mask(input logic [1:0] size);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m;
  endfunction

  // Expand a byte strobe into a bit mask over the data word.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [NB-1:0] strb);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Sign- or zero-extend the low size-bytes of an already right-shifted word.
  function automatic logic [DATA_W-1:0] ext_load(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] s32;
    logic [DATA_W-1:0]  r;
    s8  = v[7:0];
    s16 = v[15:0];
    s32 = v[31:0];
    case (size)
      2'd0:    r = uns ? DATA_W'(v[7:0])  : DATA_W'(s8);
      2'd1:    r = uns ? DATA_W'(v[15:0]) : DATA_W'(s16);
      2'd2: begin
        // A word fills the whole 32-bit datapath, so nothing to extend there.
        if (DATA_W == 32) r = v;
        else              r = uns ? DATA_W'(v[31:0]) : DATA_W'(s32);
      end
      default: r = v;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: expectation from the driver side, queue head compare
  // ---------------------------------------------------------------------------
  logic [1:0]        w_size_p0;
  logic              w_uns_p0;
  logic              w_illegal_p0;
  logic [OFF_W-1:0]  w_off_p0;
  logic [SH_W-1:0]   w_sh_p0;
  logic [NB-1:0]     w_exp_strb_p0;
  logic [DATA_W-1:0] w_exp_st_p0;
  logic [DATA_W-1:0] w_exp_ld_p0;

  assign w_size_p0     = drv_funct3[1:0];
  assign w_uns_p0      = drv_funct3[2];
  assign w_illegal_p0  = drv_valid && (w_size_p0 == 2'd3) && (DATA_W == 32);
  assign w_off_p0      = align_off(w_size_p0, drv_lsb_addr);
  assign w_sh_p0       = {w_off_p0, 3'b000};
  assign w_exp_strb_p0 = size_mask(w_size_p0) << w_off_p0;
  assign w_exp_st_p0   = (drv_st_data << w_sh_p0) & lane_mask(w_exp_strb_p0);
  assign w_exp_ld_p0   = ext_load(drv_ld_data >> w_sh_p0, w_size_p0, w_uns_p0);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic [NB-1:0]     r_q_strb [DEPTH];
  logic [DATA_W-1:0] r_q_st   [DEPTH];
  logic [DATA_W-1:0] r_q_ld   [DEPTH];

  logic w_empty_p0;
  logic w_full_p0;
  logic w_cmp_vld_p0;
  logic w_push_p0;
  logic w_overflow_p0;
  logic w_underflow_p0;

  assign w_empty_p0     = (r_count == '0);
  assign w_full_p0      = (r_count == FULL_CNT);
  assign w_cmp_vld_p0   = act_valid && !w_empty_p0;
  // A pop in the same cycle frees the slot, so a push into a full queue is
  // only dropped when nothing leaves.
  assign w_push_p0      = drv_valid && !w_illegal_p0 && (!w_full_p0 || w_cmp_vld_p0);
  assign w_overflow_p0  = drv_valid && !w_illegal_p0 && w_full_p0 && !w_cmp_vld_p0;
  assign w_underflow_p0 = act_valid && w_empty_p0;

  logic [NB-1:0]     w_head_strb_p0;
  logic [DATA_W-1:0] w_head_st_p0;
  logic [DATA_W-1:0] w_head_ld_p0;
  logic              w_cmp_err_p0;

  assign w_head_strb_p0 = r_q_strb[r_rd_ptr];
  assign w_head_st_p0   = r_q_st[r_rd_ptr];
  assign w_head_ld_p0   = r_q_ld[r_rd_ptr];
  // Store data is only meaningful on the lanes the expected strobe enables.
  assign w_cmp_err_p0   = (act_st_strb != w_head_strb_p0) ||
                          (((act_st_data ^ w_head_st_p0) & lane_mask(w_head_strb_p0)) != '0) ||
                          (act_ld_data != w_head_ld_p0);

  // Queue storage carries data only; validity comes from the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push_p0) begin
      r_q_strb[r_wr_ptr] <= w_exp_strb_p0;
      r_q_st[r_wr_ptr]   <= w_exp_st_p0;
      r_q_ld[r_wr_ptr]   <= w_exp_ld_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered pointers, counters, pulse and flags
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_chk_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_mismatch_p1;
  logic [3:0]       r_err_flags;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_chk_cnt     <= '0;
      r_err_cnt     <= '0;
      r_mismatch_p1 <= 1'b0;
      r_err_flags   <= '0;
    end else begin
      if (w_push_p0)    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_cmp_vld_p0) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push_p0 && !w_cmp_vld_p0)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push_p0 && w_cmp_vld_p0) r_count <= r_count - (PTR_W+1)'(1);

      r_mismatch_p1 <= w_cmp_vld_p0 && w_cmp_err_p0;
      if (w_cmp_vld_p0)                 r_chk_cnt <= sat_inc(r_chk_cnt);
      if (w_cmp_vld_p0 && w_cmp_err_p0) r_err_cnt <= sat_inc(r_err_cnt);

      if (w_overflow_p0)                r_err_flags[0] <= 1'b1;
      if (w_underflow_p0)               r_err_flags[1] <= 1'b1;
      if (w_illegal_p0)                 r_err_flags[2] <= 1'b1;
      if (w_cmp_vld_p0 && w_cmp_err_p0) r_err_flags[3] <= 1'b1;
    end
  end

  assign o_pending   = r_count;
  assign o_chk_cnt   = r_chk_cnt;
  assign o_err_cnt   = r_err_cnt;
  assign o_mismatch  = r_mismatch_p1;
  assign o_err_flags = r_err_flags;

`ifdef SB_LSU_DAT_ERR_MSG_EN
  // Side copy of funct3/offset so a mismatch report can name the access.
  logic [2:0]       r_q_f3  [DEPTH];
  logic [OFF_W-1:0] r_q_off [DEPTH];

  always_ff @(posedge i_clk) begin
    if (w_push_p0) begin
      r_q_f3[r_wr_ptr]  <= drv_funct3;
      r_q_off[r_wr_ptr] <= drv_lsb_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (w_cmp_vld_p0 && w_cmp_err_p0)
        $error("sb_lsu_dat mismatch: funct3=%b off=%0d exp strb=%h st=%h ld=%h act strb=%h st=%h ld=%h",
               r_q_f3[r_rd_ptr], r_q_off[r_rd_ptr], w_head_strb_p0, w_head_st_p0,
               w_head_ld_p0, act_st_strb, act_st_data, act_ld_data);
      if (w_overflow_p0)
        $error("sb_lsu_dat overflow: funct3=%b off=%0d exp strb=%h st=%h ld=%h dropped",
               drv_funct3, drv_lsb_addr, w_exp_strb_p0, w_exp_st_p0, w_exp_ld_p0);
      if (w_underflow_p0)
        $error("sb_lsu_dat underflow: act strb=%h st=%h ld=%h with empty queue",
               act_st_strb, act_st_data, act_ld_data);
      if (w_illegal_p0)
        $error("sb_lsu_dat illegal size: funct3=%b off=%0d st=%h ld=%h",
               drv_funct3, drv_lsb_addr, drv_st_data, drv_ld_data);
    end
  end
`else
  // Silent build: no reporting logic, the counters and flags above are the
  // only record of errors.
`endif

endmodule

// File: tb/tb_scoreboard_lsu_dat_pipe.sv
module tb_scoreboard_lsu_dat_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 32-bit instance, DEPTH=4, CNT_W=16
  logic        d_valid;
  logic [2:0]  d_f3;
  logic [1:0]  d_off;
  logic [31:0] d_ld, d_st;
  logic        a_valid;
  logic [31:0] a_st, a_ld;
  logic [3:0]  a_strb;
  logic [2:0]  o_pend;
  logic [15:0] o_chk, o_err;
  logic        o_mis;
  logic [3:0]  o_flg;

  // 64-bit instance, DEPTH=4, CNT_W=2 (small so saturation is reachable)
  logic        e_valid;
  logic [2:0]  e_f3;
  logic [2:0]  e_off;
  logic [63:0] e_ld, e_st;
  logic        ea_valid;
  logic [63:0] ea_st, ea_ld;
  logic [7:0]  ea_strb;
  logic [2:0]  o2_pend;
  logic [1:0]  o2_chk, o2_err;
  logic        o2_mis;
  logic [3:0]  o2_flg;

  scoreboard_lsu_dat_pipe #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n),
    .drv_valid(d_valid), .drv_funct3(d_f3), .drv_lsb_addr(d_off),
    .drv_ld_data(d_ld), .drv_st_data(d_st),
    .act_valid(a_valid), .act_st_data(a_st), .act_st_strb(a_strb), .act_ld_data(a_ld),
    .o_pending(o_pend), .o_chk_cnt(o_chk), .o_err_cnt(o_err),
    .o_mismatch(o_mis), .o_err_flags(o_flg)
  );

  scoreboard_lsu_dat_pipe #(.DATA_W(64), .DEPTH(4), .CNT_W(2)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n),
    .drv_valid(e_valid), .drv_funct3(e_f3), .drv_lsb_addr(e_off),
    .drv_ld_data(e_ld), .drv_st_data(e_st),
    .act_valid(ea_valid), .act_st_data(ea_st), .act_st_strb(ea_strb), .act_ld_data(ea_ld),
    .o_pending(o2_pend), .o_chk_cnt(o2_chk), .o_err_cnt(o2_err),
    .o_mismatch(o2_mis), .o_err_flags(o2_flg)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    d_valid = 1'b0; a_valid = 1'b0; e_valid = 1'b0; ea_valid = 1'b0;
  endtask

  task automatic d_push(input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] ld, input logic [31:0] st);
    d_valid = 1'b1; d_f3 = f3; d_off = off; d_ld = ld; d_st = st;
  endtask

  task automatic d_act(input logic [3:0] strb, input logic [31:0] st, input logic [31:0] ld);
    a_valid = 1'b1; a_strb = strb; a_st = st; a_ld = ld;
  endtask

  task automatic e_push(input logic [2:0] f3, input logic [2:0] off,
                        input logic [63:0] ld, input logic [63:0] st);
    e_valid = 1'b1; e_f3 = f3; e_off = off; e_ld = ld; e_st = st;
  endtask

  task automatic e_act(input logic [7:0] strb, input logic [63:0] st, input logic [63:0] ld);
    ea_valid = 1'b1; ea_strb = strb; ea_st = st; ea_ld = ld;
  endtask

  task automatic do_reset;
    idle();
    d_f3 = '0; d_off = '0; d_ld = '0; d_st = '0; a_st = '0; a_strb = '0; a_ld = '0;
    e_f3 = '0; e_off = '0; e_ld = '0; e_st = '0; ea_st = '0; ea_strb = '0; ea_ld = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle();
    rst_n = 1'b0;
    #1;
    n_chk++; if (o_pend !== 3'd0)  $display("FAIL rst_pend: got %0d want 0", o_pend);  else n_pass++;
    n_chk++; if (o_chk !== 16'd0)  $display("FAIL rst_chk: got %0d want 0", o_chk);   else n_pass++;
    n_chk++; if (o_err !== 16'd0)  $display("FAIL rst_err: got %0d want 0", o_err);   else n_pass++;
    n_chk++; if (o_mis !== 1'b0)   $display("FAIL rst_mis: got %b want 0", o_mis);    else n_pass++;
    n_chk++; if (o_flg !== 4'd0)   $display("FAIL rst_flg: got %b want 0000", o_flg); else n_pass++;
    n_chk++; if (o2_pend !== 3'd0) $display("FAIL rst_pend64: got %0d want 0", o2_pend); else n_pass++;
    do_reset();
  endtask

  task automatic test_load_ext32;
    do_reset();
    d_push(3'b000, 2'd3, 32'h80FF_0000, 32'h0);          // LB off 3
    tick();
    d_valid = 1'b0;
    n_chk++; if (o_pend !== 3'd1) $display("FAIL lb_pend: got %0d want 1", o_pend); else n_pass++;
    d_act(4'b1000, 32'h0, 32'hFFFF_FF80);
    tick();
    idle();
    n_chk++; if (o_chk !== 16'd1) $display("FAIL lb_chk: got %0d want 1", o_chk); else n_pass++;
    n_chk++; if (o_err !== 16'd0) $display("FAIL lb_err: got %0d want 0", o_err); else n_pass++;
    n_chk++; if (o_mis !== 1'b0)  $display("FAIL lb_mis: got %b want 0", o_mis);  else n_pass++;
    n_chk++; if (o_pend !== 3'd0) $display("FAIL lb_pend_after: got %0d want 0", o_pend); else n_pass++;
    d_push(3'b100, 2'd3, 32'h80FF_0000, 32'h0);          // LBU off 3
    tick();
    d_valid = 1'b0;
    d_act(4'b1000, 32'h0, 32'h0000_0080);
    tick();
    idle();
    n_chk++; if (o_chk !== 16'd2) $display("FAIL lbu_chk: got %0d want 2", o_chk); else n_pass++;
    n_chk++; if (o_err !== 16'd0) $display("FAIL lbu_err: got %0d want 0", o_err); else n_pass++;
  endtask

  task automatic test_store_strobe;
    do_reset();
    d_push(3'b001, 2'd3, 32'h1234_5678, 32'h0000_BEEF);  // SH off 3 -> lane 2
    tick();
    d_valid = 1'b0;
    d_act(4'b1100, 32'hBEEF_5A5A, 32'h0000_1234);        // low lanes are don't-care
    tick();
    idle();
    n_chk++; if (o_err !== 16'd0) $display("FAIL sh_pass_err: got %0d want 0", o_err); else n_pass++;
    n_chk++; if (o_flg !== 4'b0000) $display("FAIL sh_pass_flg: got %b want 0000", o_flg); else n_pass++;
    d_push(3'b001, 2'd3, 32'h1234_5678, 32'h0000_BEEF);
    tick();
    d_valid = 1'b0;
    d_act(4'b0110, 32'hBEEF_5A5A, 32'h0000_1234);        // wrong strobe
    tick();
    idle();
    n_chk++; if (o_mis !== 1'b1)    $display("FAIL sh_bad_mis: got %b want 1", o_mis); else n_pass++;
    n_chk++; if (o_err !== 16'd1)   $display("FAIL sh_bad_err: got %0d want 1", o_err); else n_pass++;
    n_chk++; if (o_chk !== 16'd2)   $display("FAIL sh_bad_chk: got %0d want 2", o_chk); else n_pass++;
    n_chk++; if (o_flg !== 4'b1000) $display("FAIL sh_bad_flg: got %b want 1000", o_flg); else n_pass++;
    tick();
    n_chk++; if (o_mis !== 1'b0)    $display("FAIL mis_pulse_width: got %b want 0", o_mis); else n_pass++;
    n_chk++; if (o_flg !== 4'b1000) $display("FAIL flg3_sticky: got %b want 1000", o_flg); else n_pass++;
    d_push(3'b000, 2'd1, 32'h0000_7F00, 32'h0000_00AB);  // SB off 1, bad enabled lane
    tick();
    d_valid = 1'b0;
    d_act(4'b0010, 32'h0000_AC00, 32'h0000_007F);
    tick();
    idle();
    n_chk++; if (o_err !== 16'd2) $display("FAIL sb_lane_err: got %0d want 2", o_err); else n_pass++;
  endtask

  task automatic test_dw64_and_illegal;
    do_reset();
    e_push(3'b110, 3'd4, 64'h8765_4321_0000_0000, 64'h0);  // LWU off 4
    tick();
    e_valid = 1'b0;
    e_act(8'hF0, 64'h0, 64'h0000_0000_8765_4321);
    tick();
    idle();
    n_chk++; if (o2_chk !== 2'd1) $display("FAIL lwu_chk: got %0d want 1", o2_chk); else n_pass++;
    n_chk++; if (o2_err !== 2'd0) $display("FAIL lwu_err: got %0d want 0", o2_err); else n_pass++;
    e_push(3'b010, 3'd6, 64'h8765_4321_0000_0000, 64'h0000_0000_CAFE_F00D);  // LW off 6 -> 4
    tick();
    e_valid = 1'b0;
    e_act(8'hF0, 64'hCAFE_F00D_0000_0000, 64'hFFFF_FFFF_8765_4321);
    tick();
    idle();
    n_chk++; if (o2_err !== 2'd0) $display("FAIL lw64_err: got %0d want 0", o2_err); else n_pass++;
    e_push(3'b011, 3'd5, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF);  // LD off 5 -> 0
    tick();
    e_valid = 1'b0;
    e_act(8'hFF, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
    tick();
    idle();
    n_chk++; if (o2_chk !== 2'd3) $display("FAIL ld64_chk: got %0d want 3", o2_chk); else n_pass++;
    n_chk++; if (o2_err !== 2'd0) $display("FAIL ld64_err: got %0d want 0", o2_err); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      e_push(3'b011, 3'd0, 64'h1111_2222_3333_4444, 64'h0);
      tick();
      e_valid = 1'b0;
      e_act(8'hFF, 64'h0, 64'h1111_2222_3333_4445);
      tick();
      idle();
    end
    n_chk++; if (o2_err !== 2'd3)    $display("FAIL sat_err: got %0d want 3", o2_err); else n_pass++;
    n_chk++; if (o2_chk !== 2'd3)    $display("FAIL sat_chk: got %0d want 3", o2_chk); else n_pass++;
    n_chk++; if (o2_flg !== 4'b1000) $display("FAIL sat_flg: got %b want 1000", o2_flg); else n_pass++;
    d_push(3'b011, 2'd0, 32'h1, 32'h2);                   // double on 32-bit
    tick();
    idle();
    n_chk++; if (o_flg !== 4'b0100) $display("FAIL illegal_flg: got %b want 0100", o_flg); else n_pass++;
    n_chk++; if (o_pend !== 3'd0)   $display("FAIL illegal_pend: got %0d want 0", o_pend); else n_pass++;
  endtask

  task automatic test_overflow_underflow;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      d_push(3'b010, 2'd0, 32'h1000_0000 + k, 32'hA000_0000 + k);
      tick();
    end
    idle();
    n_chk++; if (o_pend !== 3'd4)   $display("FAIL ovf_pend: got %0d want 4", o_pend); else n_pass++;
    n_chk++; if (o_flg !== 4'b0001) $display("FAIL ovf_flg: got %b want 0001", o_flg); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      d_act(4'hF, 32'hA000_0000 + k, 32'h1000_0000 + k);
      tick();
    end
    idle();
    n_chk++; if (o_pend !== 3'd0) $display("FAIL drain_pend: got %0d want 0", o_pend); else n_pass++;
    n_chk++; if (o_chk !== 16'd4) $display("FAIL drain_chk: got %0d want 4", o_chk); else n_pass++;
    n_chk++; if (o_err !== 16'd0) $display("FAIL drain_err: got %0d want 0", o_err); else n_pass++;
    d_act(4'hF, 32'h0, 32'h0);
    tick();
    idle();
    n_chk++; if (o_flg !== 4'b0011) $display("FAIL udf_flg: got %b want 0011", o_flg); else n_pass++;
    n_chk++; if (o_chk !== 16'd4)   $display("FAIL udf_chk: got %0d want 4", o_chk); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d_push(3'b010, 2'd0, 32'h2000_0000 + k, 32'hB000_0000 + k);
      tick();
    end
    idle();
    for (int k = 4; k < 7; k++) begin
      d_push(3'b010, 2'd0, 32'h2000_0000 + k, 32'hB000_0000 + k);
      d_act(4'hF, 32'hB000_0000 + k - 4, 32'h2000_0000 + k - 4);
      tick();
    end
    idle();
    n_chk++; if (o_pend !== 3'd4)   $display("FAIL b2b_pend: got %0d want 4", o_pend); else n_pass++;
    n_chk++; if (o_flg !== 4'b0000) $display("FAIL b2b_flg: got %b want 0000", o_flg); else n_pass++;
    for (int k = 3; k < 7; k++) begin
      d_act(4'hF, 32'hB000_0000 + k, 32'h2000_0000 + k);
      tick();
    end
    idle();
    n_chk++; if (o_pend !== 3'd0)   $display("FAIL wrap_pend: got %0d want 0", o_pend); else n_pass++;
    n_chk++; if (o_chk !== 16'd7)   $display("FAIL wrap_chk: got %0d want 7", o_chk); else n_pass++;
    n_chk++; if (o_err !== 16'd0)   $display("FAIL wrap_order_err: got %0d want 0", o_err); else n_pass++;
    n_chk++; if (o_flg !== 4'b0000) $display("FAIL wrap_flg: got %b want 0000", o_flg); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      d_push(3'b010, 2'd0, 32'h3000_0000 + k, 32'hC000_0000 + k);
      tick();
    end
    idle();
    d_act(4'hF, 32'hC000_0000, 32'h3000_0001);          // wrong load data
    tick();
    idle();
    n_chk++; if (o_pend !== 3'd3) $display("FAIL pre_rst_pend: got %0d want 3", o_pend); else n_pass++;
    n_chk++; if (o_mis !== 1'b1)  $display("FAIL pre_rst_mis: got %b want 1", o_mis); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++; if (o_pend !== 3'd0)  $display("FAIL mid_rst_pend: got %0d want 0", o_pend); else n_pass++;
    n_chk++; if (o_chk !== 16'd0)  $display("FAIL mid_rst_chk: got %0d want 0", o_chk); else n_pass++;
    n_chk++; if (o_err !== 16'd0)  $display("FAIL mid_rst_err: got %0d want 0", o_err); else n_pass++;
    n_chk++; if (o_mis !== 1'b0)   $display("FAIL mid_rst_mis: got %b want 0", o_mis); else n_pass++;
    n_chk++; if (o_flg !== 4'b0000) $display("FAIL mid_rst_flg: got %b want 0000", o_flg); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    d_act(4'hF, 32'hC000_0001, 32'h3000_0001);
    tick();
    idle();
    n_chk++; if (o_flg !== 4'b0010) $display("FAIL post_rst_flg: got %b want 0010", o_flg); else n_pass++;
    n_chk++; if (o_chk !== 16'd0)   $display("FAIL post_rst_chk: got %0d want 0", o_chk); else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_ext32();
    test_store_strobe();
    test_dw64_and_illegal();
    test_overflow_underflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scoreboard_lsu_dat_pipe.md
SCOREBOARD_LSU_DAT_PIPE -- requirements
Module: scoreboard_lsu_dat_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning load/store data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4, meaning expected-transaction queue depth; power of two, 2..16.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the check and error counters.
REQ-004 SHALL have these ports, one per line as name / direction / width / meaning:
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- drv_valid  in  1  driver transaction issued this cycle.
- drv_funct3  in  FUNCT3_WIDTH  bits [1:0] give size (00 byte, 01 half, 10 word, 11 double); bit [2] selects unsigned load.
- drv_lsb_addr  in  log2(DATA_W/8)  byte offset within the data word.
- drv_ld_data  in  DATA_W  raw memory read data.
- drv_st_data  in  DATA_W  register store data.
- act_valid  in  1  DUT result present this cycle.
- act_st_data  in  DATA_W  DUT-aligned store data.
- act_st_strb  in  DATA_W/8  DUT byte strobe.
- act_ld_data  in  DATA_W  DUT-extended load data.
- o_pending  out  log2(DEPTH)+1  queue occupancy.
- o_chk_cnt  out  CNT_W  completed comparisons.
- o_err_cnt  out  CNT_W  failed comparisons.
- o_mismatch  out  1  one-cycle pulse on a failed comparison.
- o_err_flags  out  4  sticky flags: [0] overflow, [1] underflow, [2] illegal size, [3] any mismatch.

Function
REQ-005 On drv_valid, SHALL compute the expected strobe, store data and load data, then push them with the size into the queue tail.
REQ-006 SHALL align the effective offset down to the access size: byte uses the full offset, half clears bit 0, word clears bits [1:0], double uses offset 0.
REQ-007 Expected strobe SHALL be the size mask (1, 3, F or FF) shifted left by the aligned offset.
REQ-008 Expected store data SHALL place drv_st_data's low size-bytes at the aligned byte lane.
REQ-009 Expected load data SHALL extract size-bytes from drv_ld_data at the aligned lane.
- The extracted bytes are then zero-extended to DATA_W when funct3[2]=1, sign-extended otherwise.
- Word on DATA_W=32 and double SHALL pass through unchanged.
REQ-010 Size 11 with DATA_W=32 SHALL be illegal: set flag [2], do not push.
REQ-011 On act_valid with a non-empty queue, SHALL pop the head and compare it against the actual outputs.
- act_st_strb is compared exactly.
- act_st_data is compared only on byte lanes enabled by the expected strobe.
- act_ld_data is compared exactly.
REQ-012 Comparison result SHALL be registered: o_chk_cnt increments, and on failure o_err_cnt increments and o_mismatch pulses, in the cycle after act_valid.
REQ-013 Both counters SHALL saturate at all-ones.
REQ-014 Push and pop in the same cycle on a non-empty queue SHALL both take effect, and occupancy SHALL be unchanged.
REQ-015 Push while full without a pop SHALL drop the push and set flag [0]; push while full with a pop SHALL be accepted.
REQ-016 act_valid while empty SHALL set flag [1] and perform no comparison, even if drv_valid is high that cycle; that push proceeds.
REQ-017 Queue pointers SHALL wrap modulo DEPTH; o_pending SHALL reach DEPTH when full.
REQ-018 Flags SHALL stay set until reset.

Reset
REQ-019 On i_rst_n low, SHALL asynchronously clear the queue pointers, o_pending, o_chk_cnt, o_err_cnt, o_mismatch and o_err_flags to 0.
REQ-020 Reset mid-operation SHALL discard all queued entries; no comparison SHALL complete for entries pushed before reset.

Configuration
REQ-021 With macro SB_LSU_DAT_ERR_MSG_EN defined, each mismatch, overflow, underflow or illegal size SHALL report $error with the funct3, offset, expected and actual values.
REQ-022 Without SB_LSU_DAT_ERR_MSG_EN, SHALL report no messages; counters and flags SHALL behave identically.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- DATA_W=32, LB at offset 3 with ld_data=32'h80FF_0000; DUT returns 32'hFFFF_FF80 one cycle later -> o_chk_cnt=1, o_err_cnt=0.
- DATA_W=32, SH at offset 3 with st_data=32'h0000_BEEF; DUT strb=4'b1100 and st_data=32'hBEEF_xxxx -> pass. Repeat with strb=4'b0110 -> o_mismatch pulse, o_err_cnt=1, flag[3]=1.
- DATA_W=64, LWU at offset 4 with ld_data=64'h8765_4321_0000_0000; DUT returns 64'h0000_0000_8765_4321 -> pass. DATA_W=32 with size 11 -> flag[2]=1, o_pending=0.
- DEPTH=4, five pushes with no pops -> o_pending=4, flag[0]=1. Then four act_valid -> o_pending=0, o_chk_cnt=4. One more act_valid -> flag[1]=1.
- Queue full, simultaneous push and pop -> o_pending stays 4, no overflow, FIFO order kept across pointer wrap.
- Reset asserted with 3 entries pending -> all outputs 0 immediately. After release, act_valid -> flag[1]=1.
